spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_slave_sync.sv | 32 +++
 rtl/spi_slave_ctrl.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 slave: FSM encoding and default geometry.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int SPI_BYTE_DEFAULT        = 8;
  localparam int SPI_SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_slave_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_reg;
  logic              prev_reg;

  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      chain_reg <= {STAGES{RST_VAL}};
      prev_reg  <= RST_VAL;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], async_i};
      prev_reg  <= chain_reg[STAGES-1];
    end
  end

  assign sync_o = chain_reg[STAGES-1];
  assign rise_o = chain_reg[STAGES-1] & ~prev_reg;
  assign fall_o = ~chain_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave: synchronizes SCLK/CS_n/MOSI into clk_i, shifts bytes in and
// out, and double-buffers transmit data through a one-entry holding register.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int BYTE        = SPI_BYTE_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            spi_msb_lsb_sel_i,
  input  logic [BYTE-1:0] spi_send_data_i,
  input  logic            spi_send_valid_i,
  output logic            spi_send_ready_o,
  output logic [BYTE-1:0] spi_recv_data_o,
  output logic            spi_recv_valid_o,
  output logic            spi_busy_o,
  output logic            spi_underrun_o,
  input  logic            spi_clk_i,
  input  logic            spi_cs_n_i,
  input  logic            spi_mosi_i,
  output logic            spi_miso_o
);

  localparam int CW = (BYTE > 1) ? $clog2(BYTE) : 1;
  // Pin order {mosi, cs_n, sclk}; CS_n idles high, the others low.
  localparam logic [2:0] PIN_IDLE = 3'b010;

  logic [2:0] pin_async;
  logic [2:0] pin_sync;
  logic [2:0] pin_rise;
  logic [2:0] pin_fall;

  assign pin_async = {spi_mosi_i, spi_cs_n_i, spi_clk_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      spi_slave_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (PIN_IDLE[gi])
      ) u_sync (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .async_i  (pin_async[gi]),
        .sync_o   (pin_sync[gi]),
        .rise_o   (pin_rise[gi]),
        .fall_o   (pin_fall[gi])
      );
    end
  endgenerate

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;
  logic unused_sync_bits;

  assign sclk_rise        = pin_rise[0];
  assign sclk_fall        = pin_fall[0];
  assign cs_rise          = pin_rise[1];
  assign cs_fall          = pin_fall[1];
  assign mosi_sync        = pin_sync[2];
  assign unused_sync_bits = &{1'b0, pin_sync[1:0], pin_rise[2], pin_fall[2]};

  spi_state_e      state_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [BYTE-1:0] rx_sr_reg;
  logic [BYTE-1:0] tx_sr_reg;
  logic [BYTE-1:0] hold_data_reg;
  logic            hold_full_reg;
  logic [BYTE-1:0] recv_data_reg;
  logic            recv_valid_reg;
  logic            underrun_reg;
  logic            miso_reg;
  logic            skip_fall_reg;
  logic            msb_first_reg;

  logic            hold_wr;
  logic            byte_done;
  logic            tx_load;
  logic            load_msb;
  logic [BYTE-1:0] load_data;
  logic [BYTE-1:0] rx_next;
  logic [BYTE-1:0] tx_shift;

  assign hold_wr   = spi_send_valid_i & ~hold_full_reg;
  // A CS rise in the same cycle wins over the final SCLK rise of a byte.
  assign byte_done = (state_reg == ACTIVE) & ~cs_rise & sclk_rise &
                     (bit_cnt_reg == CW'(BYTE - 1));
  assign tx_load   = ((state_reg == IDLE) & cs_fall) | byte_done;
  // The order select is only latched at CS assertion, so the first load uses the live pin.
  assign load_msb  = (state_reg == IDLE) ? spi_msb_lsb_sel_i : msb_first_reg;
  assign load_data = hold_full_reg ? hold_data_reg : '0;
  assign rx_next   = msb_first_reg ? {rx_sr_reg[BYTE-2:0], mosi_sync}
                                   : {mosi_sync, rx_sr_reg[BYTE-1:1]};
  assign tx_shift  = msb_first_reg ? {tx_sr_reg[BYTE-2:0], 1'b0}
                                   : {1'b0, tx_sr_reg[BYTE-1:1]};

  always_ff @(posedge clk_i) begin
    if (!arst_n_i) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      rx_sr_reg      <= '0;
      tx_sr_reg      <= '0;
      hold_data_reg  <= '0;
      hold_full_reg  <= 1'b0;
      recv_data_reg  <= '0;
      recv_valid_reg <= 1'b0;
      underrun_reg   <= 1'b0;
      miso_reg       <= 1'b0;
      skip_fall_reg  <= 1'b0;
      msb_first_reg  <= 1'b1;
    end else begin
      recv_valid_reg <= 1'b0;
      underrun_reg   <= 1'b0;

      // A load takes the old holding contents; a same-cycle write refills it.
      if (hold_wr) begin
        hold_data_reg <= spi_send_data_i;
      end
      hold_full_reg <= (hold_full_reg & ~tx_load) | hold_wr;

      if (tx_load) begin
        tx_sr_reg    <= load_data;
        miso_reg     <= load_msb ? load_data[BYTE-1] : load_data[0];
        underrun_reg <= ~hold_full_reg;
      end

      case (state_reg)
        IDLE: begin
          if (cs_fall) begin
            state_reg     <= ACTIVE;
            msb_first_reg <= spi_msb_lsb_sel_i;
            bit_cnt_reg   <= '0;
            rx_sr_reg     <= '0;
            skip_fall_reg <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_sr_reg     <= '0;
            skip_fall_reg <= 1'b0;
            miso_reg      <= 1'b0;
          end else if (sclk_rise) begin
            rx_sr_reg <= rx_next;
            if (byte_done) begin
              bit_cnt_reg    <= '0;
              recv_data_reg  <= rx_next;
              recv_valid_reg <= 1'b1;
              skip_fall_reg  <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (sclk_fall) begin
            // The fall right after a reload must keep the freshly loaded first bit.
            if (skip_fall_reg) begin
              skip_fall_reg <= 1'b0;
            end else begin
              tx_sr_reg <= tx_shift;
              miso_reg  <= msb_first_reg ? tx_shift[BYTE-1] : tx_shift[0];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_send_ready_o = ~hold_full_reg;
  assign spi_recv_data_o  = recv_data_reg;
  assign spi_recv_valid_o = recv_valid_reg;
  assign spi_busy_o       = (state_reg == ACTIVE);
  assign spi_underrun_o   = underrun_reg;
  assign spi_miso_o       = miso_reg;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: table of single-byte transfers, directed corner
// sequences, and random multi-byte transfers checked against a transfer-level model.
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  localparam int HALF = 4;
  localparam int LAT  = SPI_SYNC_STAGES_DEFAULT + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic [7:0] send_data;
  logic       send_valid;
  logic       ready;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       busy;
  logic       underrun;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  always #5 clk = ~clk;

  spi_slave_ctrl dut (
    .clk_i             (clk),
    .arst_n_i          (rst_n),
    .spi_msb_lsb_sel_i (sel),
    .spi_send_data_i   (send_data),
    .spi_send_valid_i  (send_valid),
    .spi_send_ready_o  (ready),
    .spi_recv_data_o   (recv_data),
    .spi_recv_valid_o  (recv_valid),
    .spi_busy_o        (busy),
    .spi_underrun_o    (underrun),
    .spi_clk_i         (sclk),
    .spi_cs_n_i        (cs_n),
    .spi_mosi_i        (mosi),
    .spi_miso_o        (miso)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_rise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: logs every received byte and counts underrun pulses.
  int         n_pulse   = 0;
  int         n_und     = 0;
  int         pulse_cyc = 0;
  logic [7:0] recv_log [0:255];

  always @(negedge clk) begin
    if (recv_valid) begin
      recv_log[n_pulse[7:0]] = recv_data;
      pulse_cyc = cyc;
      n_pulse = n_pulse + 1;
    end
    if (underrun) n_und = n_und + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic hold_write(input logic [7:0] v);
    check("ready_before_wr", {31'd0, ready}, 32'd1);
    send_data  = v;
    send_valid = 1'b1;
    tick(1);
    send_valid = 1'b0;
  endtask

  // Master side: wire bits go out/come in first-bit-at-bit-7.
  task automatic spi_bits(input int nbits, input logic [7:0] out_w, input bit do_wr,
                          input logic [7:0] wr_v, output logic [7:0] in_w);
    in_w = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = out_w[7-i];
      if (do_wr && i == 2) begin
        hold_write(wr_v);
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      in_w[7-i] = miso;
      sclk = 1'b1;
      last_rise = cyc;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input bit msb, input int nb, input logic [7:0] mosi_w [4],
                         input bit wr [5], input logic [7:0] wv [5],
                         output logic [7:0] miso_w [4]);
    sel = msb;
    if (wr[0]) hold_write(wv[0]);
    cs_n = 1'b0;
    tick(HALF);
    check("busy_active", {31'd0, busy}, 32'd1);
    for (int b = 0; b < nb; b++) spi_bits(8, mosi_w[b], wr[b+1], wv[b+1], miso_w[b]);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF + 2);
  endtask

  typedef struct {
    bit         msb;
    bit         wr;
    logic [7:0] hold;
    logic [7:0] mosi_w;
    logic [7:0] exp_miso;
    logic [7:0] exp_recv;
    int         exp_und;
  } vec_t;

  vec_t       tbl [5];
  logic [7:0] mo [4];
  logic [7:0] mi [4];
  bit         wr [5];
  logic [7:0] wv [5];
  logic [7:0] tmp;
  int         base_p, base_u, exp_und, nb;
  bit         msb;

  initial begin
    // Wire-level values: first bit on the wire is bit 7.
    tbl[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    tbl[1] = '{1'b0, 1'b1, 8'h01, 8'h80, 8'h80, 8'h01, 1};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 8'hFF, 8'h00, 8'hFF, 2};
    tbl[3] = '{1'b0, 1'b1, 8'h1E, 8'h12, 8'h78, 8'h48, 1};
    tbl[4] = '{1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1};

    rst_n = 1'b0; sel = 1'b1; send_data = '0; send_valid = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_recv_data", {24'd0, recv_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);

    for (int t = 0; t < 5; t++) begin
      base_p = n_pulse; base_u = n_und;
      mo[0] = tbl[t].mosi_w;
      for (int k = 0; k < 5; k++) begin wr[k] = 1'b0; wv[k] = 8'h00; end
      wr[0] = tbl[t].wr; wv[0] = tbl[t].hold;
      run_txn(tbl[t].msb, 1, mo, wr, wv, mi);
      $display("[TB] table %0d msb=%0d miso=%02h recv=%02h", t, tbl[t].msb, mi[0], recv_log[base_p[7:0]]);
      check("tbl_miso", {24'd0, mi[0]}, {24'd0, tbl[t].exp_miso});
      check("tbl_pulses", n_pulse - base_p, 32'd1);
      check("tbl_recv", {24'd0, recv_log[base_p[7:0]]}, {24'd0, tbl[t].exp_recv});
      check("tbl_underruns", n_und - base_u, tbl[t].exp_und);
      check("tbl_busy_idle", {31'd0, busy}, 32'd0);
      check("tbl_ready", {31'd0, ready}, 32'd1);
    end

    // Back-to-back bytes, second holding value written during byte 1.
    base_p = n_pulse; base_u = n_und;
    mo[0] = 8'hAB; mo[1] = 8'hCD;
    for (int k = 0; k < 5; k++) begin wr[k] = 1'b0; wv[k] = 8'h00; end
    wr[0] = 1'b1; wv[0] = 8'h11; wr[1] = 1'b1; wv[1] = 8'h22;
    run_txn(1'b1, 2, mo, wr, wv, mi);
    $display("[TB] b2b miso=%02h,%02h pulses=%0d", mi[0], mi[1], n_pulse - base_p);
    check("b2b_miso0", {24'd0, mi[0]}, 32'h11);
    check("b2b_miso1", {24'd0, mi[1]}, 32'h22);
    check("b2b_pulses", n_pulse - base_p, 32'd2);
    check("b2b_recv0", {24'd0, recv_log[base_p[7:0]]}, 32'hAB);
    check("b2b_recv1", {24'd0, recv_log[8'(base_p + 1)]}, 32'hCD);
    check("b2b_underruns", n_und - base_u, 32'd1);
    check("recv_latency", pulse_cyc - last_rise, LAT);

    // CS released after 5 rises: partial byte dropped, holding write kept.
    base_p = n_pulse; base_u = n_und;
    sel = 1'b1;
    cs_n = 1'b0;
    tick(HALF);
    spi_bits(5, 8'hFF, 1'b1, 8'h77, tmp);
    tick(HALF);
    cs_n = 1'b1;
    tick(HALF + 2);
    $display("[TB] abort pulses=%0d busy=%0d ready=%0d", n_pulse - base_p, busy, ready);
    check("abort_pulses", n_pulse - base_p, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready_held", {31'd0, ready}, 32'd0);
    check("abort_miso_idle", {31'd0, miso}, 32'd0);
    check("abort_underruns", n_und - base_u, 32'd1);
    base_p = n_pulse; base_u = n_und;
    mo[0] = 8'h5A;
    for (int k = 0; k < 5; k++) begin wr[k] = 1'b0; wv[k] = 8'h00; end
    run_txn(1'b1, 1, mo, wr, wv, mi);
    $display("[TB] after-abort miso=%02h recv=%02h", mi[0], recv_log[base_p[7:0]]);
    check("post_abort_miso", {24'd0, mi[0]}, 32'h77);
    check("post_abort_pulses", n_pulse - base_p, 32'd1);
    check("post_abort_recv", {24'd0, recv_log[base_p[7:0]]}, 32'h5A);
    check("post_abort_underruns", n_und - base_u, 32'd1);

    // Random multi-byte transfers against the transfer-level model.
    for (int t = 0; t < 20; t++) begin
      msb = 1'($urandom_range(0, 1));
      nb  = int'($urandom_range(1, 3));
      for (int k = 0; k < 5; k++) begin
        wr[k] = (k <= nb) ? 1'($urandom_range(0, 1)) : 1'b0;
        wv[k] = 8'($urandom);
      end
      for (int b = 0; b < 4; b++) mo[b] = 8'($urandom);
      base_p = n_pulse; base_u = n_und;
      run_txn(msb, nb, mo, wr, wv, mi);
      $display("[TB] rand %0d msb=%0d bytes=%0d pulses=%0d", t, msb, nb, n_pulse - base_p);
      exp_und = 0;
      for (int k = 0; k <= nb; k++) if (!wr[k]) exp_und++;
      for (int b = 0; b < nb; b++) begin
        tmp = wr[b] ? wv[b] : 8'h00;
        check("rand_miso", {24'd0, mi[b]}, {24'd0, msb ? tmp : rev8(tmp)});
        check("rand_recv", {24'd0, recv_log[8'(base_p + b)]}, {24'd0, msb ? mo[b] : rev8(mo[b])});
      end
      check("rand_pulses", n_pulse - base_p, nb);
      check("rand_underruns", n_und - base_u, exp_und);
      check("rand_ready", {31'd0, ready}, 32'd1);
    end

    // Reset after 3 rises with a pending holding write.
    base_p = n_pulse;
    sel = 1'b1;
    cs_n = 1'b0;
    tick(HALF);
    spi_bits(3, 8'hC3, 1'b1, 8'h99, tmp);
    check("pre_rst_ready", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    tick(2);
    cs_n = 1'b1;
    tick(SPI_SYNC_STAGES_DEFAULT + 3);
    rst_n = 1'b1;
    tick(1);
    $display("[TB] mid-reset ready=%0d recv=%02h busy=%0d miso=%0d", ready, recv_data, busy, miso);
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_recv_data", {24'd0, recv_data}, 32'd0);
    check("mid_rst_recv_valid", {31'd0, recv_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    tick(HALF * 2);
    check("mid_rst_pulses", n_pulse - base_p, 32'd0);
    check("mid_rst_busy_later", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
